// File: rtl/framebuffer_display.sv
// framebuffer_display: VGA scan-out of a cell-mapped framebuffer; define DISPLAY_PALETTE16_EN for a 16-entry palette
module framebuffer_display #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  parameter int CELL_SIZE = 15,
  parameter int X_OFFSET = 80,
  parameter logic [15:0] BASE_ADDR = 16'h0200,
  parameter int RD_LATENCY = 1,
  parameter int BORDER_W = 8,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  color_data,
  output logic [15:0] color_address,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);
  localparam logic [15:0] HT = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] VT = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] HA = 16'(H_ACTIVE);
  localparam logic [15:0] VA = 16'(V_ACTIVE);
  localparam logic [15:0] HS0 = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS1 = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS0 = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS1 = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] GX0 = 16'(X_OFFSET);
  localparam logic [15:0] GX1 = 16'(X_OFFSET + GRID_W * CELL_SIZE);
  localparam logic [15:0] GY1 = 16'(GRID_H * CELL_SIZE);
  localparam logic [15:0] BL = 16'((X_OFFSET > BORDER_W) ? X_OFFSET - BORDER_W : 0);
  localparam logic [15:0] BR = 16'(X_OFFSET + GRID_W * CELL_SIZE + BORDER_W);
  localparam logic [15:0] CS = 16'(CELL_SIZE - 1);
  localparam logic [15:0] GW = 16'(GRID_W);
  localparam logic [11:0] PAL [16] = '{12'h000, 12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
                                       12'hF80, 12'h840, 12'hF88, 12'h444, 12'h888, 12'h8F8, 12'h88F, 12'hCCC};
  logic [15:0] hcnt, vcnt, hnext, sub_x, cell_x, sub_y, cell_y;
  logic        h_end, v_end, active, in_grid, border, hs, vs, fs;
  logic [5:0]  pipe [RD_LATENCY+1];
  logic [5:0]  last;
  logic [3:0]  idx;
  logic [11:0] px;
`ifdef DISPLAY_PALETTE16_EN
  logic unused_bits;
  assign unused_bits = ^color_data[7:4];
  assign idx = color_data[3:0];
`else
  logic unused_bits;
  assign unused_bits = ^color_data[7:3];
  assign idx = {1'b0, color_data[2:0]};
`endif
  always_comb begin
    h_end = hcnt == HT - 16'd1;
    v_end = vcnt == VT - 16'd1;
    hnext = h_end ? 16'd0 : hcnt + 16'd1;
    active = hcnt < HA && vcnt < VA;
    in_grid = hcnt >= GX0 && hcnt < GX1 && vcnt < GY1;
    border = active && ((hcnt >= BL && hcnt < GX0) || (hcnt >= GX1 && hcnt < BR));
    hs = hcnt >= HS0 && hcnt < HS1;
    vs = vcnt >= VS0 && vcnt < VS1;
    fs = hcnt == 16'd0 && vcnt == 16'd0;
    last = pipe[RD_LATENCY];
    // flags in the last pipe slot line up with the color_data returned for them
    px = !last[5] ? 12'h000 : last[4] ? BORDER_COLOR : last[3] ? PAL[idx] : 12'h000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      sub_x <= '0;
      cell_x <= '0;
      sub_y <= '0;
      cell_y <= '0;
      color_address <= BASE_ADDR;
      for (int i = 0; i <= RD_LATENCY; i++) pipe[i] <= '0;
      {red, green, blue} <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hcnt <= hnext;
      if (h_end) vcnt <= v_end ? 16'd0 : vcnt + 16'd1;
      if (hnext == GX0) begin
        sub_x <= '0;
        cell_x <= '0;
      end else if (sub_x == CS) begin
        sub_x <= '0;
        cell_x <= cell_x + 16'd1;
      end else sub_x <= sub_x + 16'd1;
      if (h_end && v_end) begin
        sub_y <= '0;
        cell_y <= '0;
      end else if (h_end && vcnt < VA) begin
        sub_y <= sub_y == CS ? 16'd0 : sub_y + 16'd1;
        cell_y <= sub_y == CS ? cell_y + 16'd1 : cell_y;
      end
      color_address <= in_grid ? BASE_ADDR + cell_y * GW + cell_x : BASE_ADDR;
      pipe[0] <= {active, border, in_grid, hs, vs, fs};
      for (int i = 1; i <= RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      {red, green, blue} <= px;
      hsync <= ~last[2];
      vsync <= ~last[1];
      frame_start <= last[0];
    end
  end
endmodule

// File: tb/tb_framebuffer_display.sv
// tb_framebuffer_display: directed checks of two scan-out instances (read latency 1 and 3) with a shortened frame
module tb_framebuffer_display;
  localparam int HT = 800;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] d1, d3, fill;
  logic mode;
  logic [15:0] a1, a3, q1;
  logic [15:0] q3 [3];
  logic [3:0] r1, g1, b1, r3, g3, b3;
  logic hs1, vs1, fs1, hs3, vs3, fs3;
  int cyc, n_checks, n_fail;
  int hs_first, hs_last, hs_per, hs_low, hs_nf, hs3_first, hs3_nf;
  int vs_first, vs_last, vs_per, vs_low, vs_nf;
  int fs_n, fs_last, fs3_n;
  logic hs_p = 1'b1, vs_p = 1'b1, hs3_p = 1'b1;

  always #5 clk = ~clk;

  framebuffer_display #(.V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .GRID_H(3), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .color_data(d1), .color_address(a1), .red(r1), .green(g1), .blue(b1),
    .hsync(hs1), .vsync(vs1), .frame_start(fs1));
  framebuffer_display #(.V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .GRID_H(3), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .color_data(d3), .color_address(a3), .red(r3), .green(g3), .blue(b3),
    .hsync(hs3), .vsync(vs3), .frame_start(fs3));

  always @(posedge clk) begin
    q1 <= a1;
    q3[0] <= a3;
    q3[1] <= q3[0];
    q3[2] <= q3[1];
    cyc <= rst ? 0 : cyc + 1;
  end
  assign d1 = mode ? q1[7:0] : fill;
  assign d3 = mode ? q3[2][7:0] : fill;

  always @(negedge clk) if (!rst) begin
    hs_p <= hs1;
    vs_p <= vs1;
    hs3_p <= hs3;
    if (hs_p && !hs1) begin
      if (hs_nf == 0) hs_first <= cyc; else hs_per <= cyc - hs_last;
      hs_last <= cyc;
      hs_nf <= hs_nf + 1;
    end
    if (!hs_p && hs1) hs_low <= cyc - hs_last;
    if (vs_p && !vs1) begin
      if (vs_nf == 0) vs_first <= cyc; else vs_per <= cyc - vs_last;
      vs_last <= cyc;
      vs_nf <= vs_nf + 1;
    end
    if (!vs_p && vs1) vs_low <= cyc - vs_last;
    if (hs3_p && !hs3) begin
      if (hs3_nf == 0) hs3_first <= cyc;
      hs3_nf <= hs3_nf + 1;
    end
    if (fs1) begin
      fs_n <= fs_n + 1;
      fs_last <= cyc;
    end
    if (fs3) fs3_n <= fs3_n + 1;
  end

  function automatic logic [11:0] pal(input logic [7:0] d);
    logic [3:0] i;
`ifdef DISPLAY_PALETTE16_EN
    i = d[3:0];
`else
    i = {1'b0, d[2:0]};
`endif
    case (i)
      4'd0: return 12'h000;
      4'd1: return 12'hFFF;
      4'd2: return 12'hF00;
      4'd3: return 12'h0F0;
      4'd4: return 12'h00F;
      4'd5: return 12'hFF0;
      4'd6: return 12'h0FF;
      4'd7: return 12'hF0F;
      4'd8: return 12'hF80;
      4'd9: return 12'h840;
      4'd10: return 12'hF88;
      4'd11: return 12'h444;
      4'd12: return 12'h888;
      4'd13: return 12'h8F8;
      4'd14: return 12'h88F;
      default: return 12'hCCC;
    endcase
  endfunction

  function automatic logic [11:0] rgb(input int w);
    return w == 1 ? {r1, g1, b1} : {r3, g3, b3};
  endfunction

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mode = 1'b1;
    fill = 8'h00;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({hs1, vs1, r1, g1, b1, a1, fs1} !== {1'b1, 1'b1, 12'h000, 16'h0200, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_lat1: got hs=%b vs=%b rgb=%h addr=%h fs=%b", hs1, vs1, {r1, g1, b1}, a1, fs1);
    end
    n_checks++;
    if ({hs3, vs3, r3, g3, b3, a3, fs3} !== {1'b1, 1'b1, 12'h000, 16'h0200, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_lat3: got hs=%b vs=%b rgb=%h addr=%h fs=%b", hs3, vs3, {r3, g3, b3}, a3, fs3);
    end
    rst = 1'b0;
    at(2);
    n_checks++;
    if (fs1 !== 1'b0) begin n_fail++; $display("FAIL fs_early: got %b expected 0", fs1); end
    at(3);
    n_checks++;
    if (fs1 !== 1'b1) begin n_fail++; $display("FAIL fs_lat1: got %b expected 1", fs1); end
    at(4);
    n_checks++;
    if (fs1 !== 1'b0) begin n_fail++; $display("FAIL fs_width: got %b expected 0", fs1); end
    at(5);
    n_checks++;
    if (fs3 !== 1'b1) begin n_fail++; $display("FAIL fs_lat3: got %b expected 1", fs3); end
  endtask

  // memory returns the low address byte, so cell k shows palette entry k
  task automatic test_cells(input int w, input int line, input int lat);
    int xs [14] = '{0, 71, 72, 79, 80, 94, 95, 109, 110, 559, 560, 567, 568, 640};
    logic [11:0] ex [14];
    ex = '{12'h000, 12'h000, 12'hFFF, 12'hFFF, pal(8'h00), pal(8'h00), pal(8'h01), pal(8'h01), pal(8'h02),
           pal(8'h1F), 12'hFFF, 12'hFFF, 12'h000, 12'h000};
    for (int i = 0; i < 14; i++) begin
      at(line * HT + xs[i] + lat);
      n_checks++;
      if (rgb(w) !== ex[i]) begin
        n_fail++;
        $display("FAIL cells_lat%0d x=%0d: got %h expected %h", lat, xs[i], rgb(w), ex[i]);
      end
    end
  endtask

  task automatic test_grid_edges(input int w, input int line, input int lat);
    int xs [6] = '{79, 80, 559, 560, 640, 700};
    logic [11:0] ex [6] = '{12'hFFF, 12'hF00, 12'hF00, 12'hFFF, 12'h000, 12'h000};
    for (int i = 0; i < 6; i++) begin
      at(line * HT + xs[i] + lat);
      n_checks++;
      if (rgb(w) !== ex[i]) begin
        n_fail++;
        $display("FAIL edges_lat%0d x=%0d: got %h expected %h", lat, xs[i], rgb(w), ex[i]);
      end
    end
  endtask

  task automatic test_palette_hi;
    at(4 * HT);
    fill = 8'h08;
    at(4 * HT + 200 + 1);
    n_checks++;
    if (rgb(1) !== pal(8'h08)) begin n_fail++; $display("FAIL pal08_lat1: got %h expected %h", rgb(1), pal(8'h08)); end
    at(5 * HT + 200 + 3);
    n_checks++;
    if (rgb(3) !== pal(8'h08)) begin n_fail++; $display("FAIL pal08_lat3: got %h expected %h", rgb(3), pal(8'h08)); end
    at(6 * HT);
    fill = 8'hFA;
    at(6 * HT + 300 + 1);
    n_checks++;
    if (rgb(1) !== pal(8'hFA)) begin n_fail++; $display("FAIL palFA_lat1: got %h expected %h", rgb(1), pal(8'hFA)); end
    at(7 * HT + 300 + 3);
    n_checks++;
    if (rgb(3) !== pal(8'hFA)) begin n_fail++; $display("FAIL palFA_lat3: got %h expected %h", rgb(3), pal(8'hFA)); end
    fill = 8'h02;
  endtask

  task automatic test_address;
    int xs [10] = '{79, 80, 94, 95, 559, 560, 80, 95, 559, 80};
    int ys [10] = '{8, 8, 8, 8, 8, 8, 15, 15, 44, 45};
    logic [15:0] ex [10] = '{16'h0200, 16'h0200, 16'h0200, 16'h0201, 16'h021F, 16'h0200,
                             16'h0220, 16'h0221, 16'h025F, 16'h0200};
    for (int i = 0; i < 10; i++) begin
      at(ys[i] * HT + xs[i] + 1);
      n_checks++;
      if (a1 !== ex[i]) begin n_fail++; $display("FAIL addr_lat1 (%0d,%0d): got %h expected %h", xs[i], ys[i], a1, ex[i]); end
      n_checks++;
      if (a3 !== ex[i]) begin n_fail++; $display("FAIL addr_lat3 (%0d,%0d): got %h expected %h", xs[i], ys[i], a3, ex[i]); end
    end
  endtask

  task automatic test_blanking;
    int xs [3] = '{75, 200, 200};
    int ys [3] = '{46, 47, 50};
    logic [11:0] ex [3] = '{12'hFFF, 12'h000, 12'h000};
    for (int i = 0; i < 3; i++) begin
      at(ys[i] * HT + xs[i] + 1);
      n_checks++;
      if (rgb(1) !== ex[i]) begin n_fail++; $display("FAIL blank_lat1 (%0d,%0d): got %h expected %h", xs[i], ys[i], rgb(1), ex[i]); end
      at(ys[i] * HT + xs[i] + 3);
      n_checks++;
      if (rgb(3) !== ex[i]) begin n_fail++; $display("FAIL blank_lat3 (%0d,%0d): got %h expected %h", xs[i], ys[i], rgb(3), ex[i]); end
    end
  endtask

  task automatic test_sync;
    at(85000);
    n_checks++;
    if (hs_first !== 659) begin n_fail++; $display("FAIL hs_first_lat1: got %0d expected 659", hs_first); end
    n_checks++;
    if (hs3_first !== 661) begin n_fail++; $display("FAIL hs_first_lat3: got %0d expected 661", hs3_first); end
    n_checks++;
    if (hs_low !== 96) begin n_fail++; $display("FAIL hs_low: got %0d expected 96", hs_low); end
    n_checks++;
    if (hs_per !== 800) begin n_fail++; $display("FAIL hs_period: got %0d expected 800", hs_per); end
    n_checks++;
    if (vs_first !== 40003) begin n_fail++; $display("FAIL vs_first: got %0d expected 40003", vs_first); end
    n_checks++;
    if (vs_low !== 1600) begin n_fail++; $display("FAIL vs_low: got %0d expected 1600", vs_low); end
    n_checks++;
    if (vs_per !== 44000) begin n_fail++; $display("FAIL vs_period: got %0d expected 44000", vs_per); end
    n_checks++;
    if (fs_n !== 2) begin n_fail++; $display("FAIL fs_count_lat1: got %0d expected 2", fs_n); end
    n_checks++;
    if (fs_last !== 44003) begin n_fail++; $display("FAIL fs_second: got %0d expected 44003", fs_last); end
    n_checks++;
    if (fs3_n !== 2) begin n_fail++; $display("FAIL fs_count_lat3: got %0d expected 2", fs3_n); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset;
    test_cells(1, 0, 3);
    test_cells(3, 1, 5);
    at(2 * HT);
    mode = 1'b0;
    fill = 8'h02;
    test_grid_edges(1, 2, 3);
    test_grid_edges(3, 3, 5);
    test_palette_hi;
    test_address;
    test_blanking;
    test_sync;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
